// File: rtl/pwm_audio_out.sv
// rtl/pwm_audio_out.sv - Multi-channel PWM audio output with slewed volume gain.
// Optional LFSR dither before truncation is enabled by defining PWMOUT_DITHER_EN.
module pwm_audio_out #(
   parameter int unsigned PWM_BITS   = 12,
   parameter int unsigned CHANNELS   = 2,
   parameter int unsigned RAMP_SHIFT = 4,
   parameter logic [5:0]  CMD_ADDR   = 6'h0f
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          enable_i,
   input  logic [16*CHANNELS-1:0]        s_tdata_i,
   input  logic                          s_tvalid_i,
   output logic                          s_tready_o,
   input  logic [5:0]                    cmd_addr_i,
   input  logic [31:0]                   cmd_data_i,
   input  logic                          cmd_rqst_i,
   output logic [CHANNELS-1:0]           pwm_out_o,
   output logic                          period_start_o,
   output logic                          muted_o
);
   localparam int unsigned         DIV_W   = (RAMP_SHIFT > 0) ? RAMP_SHIFT : 1;
   localparam logic [DIV_W-1:0]    DIV_MAX = DIV_W'((32'd1 << RAMP_SHIFT) - 32'd1);
   localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

   logic [PWM_BITS-1:0]               cnt_q, cnt_d;
   logic [DIV_W-1:0]                  div_q, div_d;
   logic [7:0]                        ramp_q, ramp_d, vol_q, vol_d, target;
   logic                              pend_q, pend_d;
   logic [16*CHANNELS-1:0]            buf_q, buf_d, act_q, act_d;
   logic [CHANNELS-1:0][PWM_BITS-1:0] duty_q, duty_d, duty_nx;
   logic [CHANNELS-1:0]               pwm_q, pwm_d;
   logic                              muted, wrap, step, accept;

   assign muted  = (ramp_q == 8'd0) && !enable_i;
   assign wrap   = !muted && (cnt_q == CNT_MAX);
   assign step   = wrap && (div_q == DIV_MAX);
   assign accept = s_tvalid_i && !pend_q;
   assign target = enable_i ? vol_q : 8'd0;

   always_comb begin
      cnt_d = muted ? '0 : cnt_q + 1'b1;

      div_d = div_q;
      if (muted) begin
         div_d = '0;
      end else if (wrap) begin
         div_d = (div_q == DIV_MAX) ? '0 : div_q + 1'b1;
      end

      // single-step slew toward the target never overshoots it
      ramp_d = ramp_q;
      if (step) begin
         if (ramp_q < target) begin
            ramp_d = ramp_q + 8'd1;
         end else if (ramp_q > target) begin
            ramp_d = ramp_q - 8'd1;
         end
      end

      vol_d = (cmd_rqst_i && (cmd_addr_i == CMD_ADDR)) ? cmd_data_i[23:16] : vol_q;

      pend_d = pend_q;
      buf_d  = buf_q;
      act_d  = act_q;
      if (wrap && pend_q) begin
         act_d  = buf_q;
         pend_d = 1'b0;
      end
      if (accept) begin
         buf_d  = s_tdata_i;
         pend_d = 1'b1;
      end

      duty_d = wrap ? duty_nx : duty_q;
   end

`ifdef PWMOUT_DITHER_EN
   localparam logic [15:0] DITH_MASK = 16'((32'd1 << (16 - PWM_BITS)) - 32'd1);
   logic [15:0] lfsr_q, lfsr_d, dith;
   assign lfsr_d = wrap ? {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]}
                        : lfsr_q;
   assign dith   = lfsr_q & DITH_MASK;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lfsr_q <= 16'hACE1;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end
`endif

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic signed [24:0] smp_x, rmp_x, prod;
      logic [15:0]        scaled_raw, scaled;
      logic [8:0]         unused_prod;

      assign smp_x       = {{9{act_d[16*c+15]}}, act_d[16*c +: 16]};
      assign rmp_x       = {17'd0, ramp_q};
      assign prod        = smp_x * rmp_x;
      assign scaled_raw  = prod[23:8];
      assign unused_prod = {prod[24], prod[7:0]};

`ifdef PWMOUT_DITHER_EN
      logic [15:0] sum;
      assign sum    = scaled_raw + dith;
      assign scaled = (!scaled_raw[15] && sum[15]) ? 16'h7fff : sum;
`else
      assign scaled = scaled_raw;
`endif

      // offset-binary: flipping the sign bit maps -32768..32767 onto 0..full scale
      assign duty_nx[c] = {~scaled[15], scaled[14 -: PWM_BITS-1]};
      assign pwm_d[c]   = !muted && (cnt_q < duty_q[c]);
   end

   logic [23:0] unused_cmd;
   assign unused_cmd = {cmd_data_i[31:24], cmd_data_i[15:0]};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q  <= '0;
         div_q  <= '0;
         ramp_q <= 8'd0;
         vol_q  <= 8'd0;
         pend_q <= 1'b0;
         buf_q  <= '0;
         act_q  <= '0;
         duty_q <= '0;
         pwm_q  <= '0;
      end else begin
         cnt_q  <= cnt_d;
         div_q  <= div_d;
         ramp_q <= ramp_d;
         vol_q  <= vol_d;
         pend_q <= pend_d;
         buf_q  <= buf_d;
         act_q  <= act_d;
         duty_q <= duty_d;
         pwm_q  <= pwm_d;
      end
   end

   assign s_tready_o     = !pend_q;
   assign pwm_out_o      = pwm_q;
   assign period_start_o = wrap;
   assign muted_o        = muted;

endmodule

// File: tb/tb_pwm_audio_out.sv
// tb/tb_pwm_audio_out.sv - Self-checking bench for pwm_audio_out (8-bit PWM, 2 channels).
module tb_pwm_audio_out;
   localparam int PB = 8;
   localparam int CH = 2;
   localparam int RS = 1;
   localparam int P  = 256;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            enable = 1'b0;
   logic [16*CH-1:0] s_tdata = '0;
   logic            s_tvalid = 1'b0;
   logic            s_tready;
   logic [5:0]      cmd_addr = '0;
   logic [31:0]     cmd_data = '0;
   logic            cmd_rqst = 1'b0;
   logic [CH-1:0]   pwm_out;
   logic            period_start;
   logic            muted;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   always #5 clk = ~clk;

   pwm_audio_out #(.PWM_BITS(PB), .CHANNELS(CH), .RAMP_SHIFT(RS), .CMD_ADDR(6'h0f)) dut (
      .clk_i(clk), .rst_ni(rst_n), .enable_i(enable),
      .s_tdata_i(s_tdata), .s_tvalid_i(s_tvalid), .s_tready_o(s_tready),
      .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data), .cmd_rqst_i(cmd_rqst),
      .pwm_out_o(pwm_out), .period_start_o(period_start), .muted_o(muted)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: duty is the signed sample scaled by ramp/256 (floored), offset by half scale,
   // then reduced to PB bits.
   function automatic int duty_of(input int s, input int r);
      int sc;
      sc = (s * r) >>> 8;
      return (sc + 32768) >>> (16 - PB);
   endfunction

   int m_ramp, m_vol, m_pos, m_nper;
   bit m_pend;
   int m_buf[CH], m_act[CH], m_duty[CH];
   bit m_pwm[CH];
   bit m_mu, m_ps, m_acc;
   int m_tgt;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_ramp = 0; m_vol = 0; m_pos = 0; m_nper = 0; m_pend = 0;
         for (int c = 0; c < CH; c++) begin
            m_buf[c] = 0; m_act[c] = 0; m_duty[c] = 0; m_pwm[c] = 0;
         end
      end else begin
         m_mu  = (m_ramp == 0) && !enable;
         m_ps  = !m_mu && (m_pos == P - 1);
         m_acc = s_tvalid && !m_pend;
         for (int c = 0; c < CH; c++) m_pwm[c] = !m_mu && (m_pos < m_duty[c]);
         if (m_ps) begin
            if (m_pend) begin
               for (int c = 0; c < CH; c++) m_act[c] = m_buf[c];
               m_pend = 0;
            end
            for (int c = 0; c < CH; c++) m_duty[c] = duty_of(m_act[c], m_ramp);
            m_nper++;
            if (m_nper % (1 << RS) == 0) begin
               m_tgt = enable ? m_vol : 0;
               if (m_ramp < m_tgt) m_ramp++;
               else if (m_ramp > m_tgt) m_ramp--;
            end
         end
         if (m_mu) m_nper = 0;
         if (m_acc) begin
            for (int c = 0; c < CH; c++) m_buf[c] = int'($signed(s_tdata[16*c +: 16]));
            m_pend = 1;
         end
         if (cmd_rqst && cmd_addr == 6'h0f) m_vol = int'(cmd_data[23:16]);
         m_pos = m_mu ? 0 : (m_pos + 1) % P;
      end
   end

   bit c_mu;
   always @(negedge clk) begin
      if (cmp_en) begin
         c_mu = (m_ramp == 0) && !enable;
         chk("muted", muted, c_mu);
         chk("s_tready", s_tready, !m_pend);
         chk("period_start", period_start, !c_mu && (m_pos == P - 1));
         for (int c = 0; c < CH; c++) chk("pwm_out", pwm_out[c], m_pwm[c]);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cmd(input logic [5:0] a, input logic [7:0] v);
      cmd_addr = a;
      cmd_data = {8'h5a, v, 16'ha5c3};
      cmd_rqst = 1'b1;
      tick();
      cmd_rqst = 1'b0;
   endtask

   task automatic wait_periods(input int n);
      int seen = 0;
      int budget = (n + 2) * P;
      while (seen < n && budget > 0) begin
         @(negedge clk);
         budget--;
         if (period_start) seen++;
      end
      if (seen < n) begin
         checks++; errors++;
         $display("FAIL wait_periods actual=%0d required=%0d", seen, n);
      end
   endtask

   task automatic finish_send(input string name);
      int budget = 4 * P;
      bit done = 0;
      while (!done && budget > 0) begin
         @(negedge clk);
         budget--;
         if (s_tready) begin
            tick();
            done = 1;
         end
      end
      s_tvalid = 1'b0;
      if (!done) begin
         checks++; errors++;
         $display("FAIL %s actual=stalled required=accepted", name);
      end
   endtask

   task automatic send(input logic [15:0] d0, input logic [15:0] d1);
      s_tdata  = {d1, d0};
      s_tvalid = 1'b1;
      finish_send("send");
   endtask

   task automatic count_high(input int ch, output int n);
      n = 0;
      repeat (P) begin
         @(negedge clk);
         n += int'(pwm_out[ch]);
      end
   endtask

   int n;

   initial begin
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_pwm", pwm_out, 0);
      chk("rst_muted", muted, 1);
      chk("rst_tready", s_tready, 1);
      chk("rst_pstart", period_start, 0);
      cmp_en = 1'b1;

      repeat (300) tick();
      chk("idle_muted", muted, 1);
      chk("idle_pwm", pwm_out, 0);

      cmd(6'h10, 8'd200);
      cmd(6'h0f, 8'd32);
      send(16'h7fff, 16'h8000);

      enable = 1'b1;
      @(negedge clk);
      chk("unmute", muted, 0);
      wait_periods(70);
      count_high(0, n); chk("high_7fff_r32", n, 143);
      count_high(1, n); chk("high_8000_r32", n, 112);

      wait_periods(1);
      repeat (50) tick();
      send(16'h0000, 16'h7fff);
      s_tdata  = {16'h0000, 16'h8000};
      s_tvalid = 1'b1;
      @(negedge clk);
      chk("b2b_stall", s_tready, 0);
      finish_send("send_b");
      wait_periods(2);
      count_high(0, n); chk("b2b_second_ch0", n, 112);
      count_high(1, n); chk("b2b_second_ch1", n, 128);

      cmd(6'h0f, 8'd20);
      cmd(6'h10, 8'd0);
      wait_periods(30);
      send(16'h8000, 16'h7fff);
      wait_periods(3);
      count_high(1, n); chk("high_7fff_r20", n, 137);
      count_high(0, n); chk("high_8000_r20", n, 118);

      enable = 1'b0;
      repeat (45 * P) tick();
      @(negedge clk);
      chk("ramp_down_muted", muted, 1);
      chk("ramp_down_pwm", pwm_out, 0);

      tick();
      enable = 1'b1;
      @(negedge clk);
      chk("reenable_muted", muted, 0);
      wait_periods(4);
      count_high(1, n); chk("climb_ch1", n, 128);
      count_high(0, n); chk("climb_ch0", n, 127);

      cmp_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
